bus_arbiter: RTL and testbench

Shares the single external memory port between instruction fetch and the memory stage's load/store interface. Sits between the pipeline and the external bus. Grants one requester at a time and runs a valid/ready transaction on the external port. For data accesses it generates byte enables, places store data in the correct byte lanes, and aligns and sign- or zero-extends load data. The hazard unit uses `fetch_ready` and `data_ready` to hold each stage until its access completes.

---
 rtl/bus_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_bus_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Shares the external memory port between fetch and load/store with lane steering.
// Define BUS_ARB_FAIR_EN to let a starved fetch win the next contested arbitration.
module bus_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [31:0] fetch_address,
    output logic [31:0] fetch_data,
    output logic        fetch_ready,
    input  logic        data_load,
    input  logic        data_store,
    input  logic [31:0] data_address,
    input  logic [31:0] data_store_data,
    input  logic [1:0]  data_size,
    input  logic        data_signed,
    output logic [31:0] data_load_data,
    output logic        data_ready,
    output logic        ext_valid,
    output logic        ext_write,
    output logic [31:0] ext_address,
    output logic [3:0]  ext_byte_enable,
    output logic [31:0] ext_write_data,
    input  logic        ext_ready,
    input  logic [31:0] ext_read_data
);

    typedef enum logic [1:0] {IDLE, FETCH, DATA, RESP} state_t;

    state_t      state_q, state_d;
    logic        ext_valid_q, ext_valid_d;
    logic        ext_write_q, ext_write_d;
    logic [31:0] ext_address_q, ext_address_d;
    logic [3:0]  ext_be_q, ext_be_d;
    logic [31:0] ext_wdata_q, ext_wdata_d;
    logic [31:0] fetch_data_q, fetch_data_d;
    logic [31:0] load_data_q, load_data_d;
    logic        fetch_ready_q, fetch_ready_d;
    logic        data_ready_q, data_ready_d;
    logic [1:0]  lane_q, lane_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;

    logic        data_req, legal, pick_fetch;
    logic [3:0]  st_be;
    logic [31:0] st_wdata, ld_ext;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        unused_bits;

    assign unused_bits = &{1'b0, fetch_address[1:0]};
    assign data_req    = data_load | data_store;

    always_comb begin
        legal    = 1'b0;
        st_be    = 4'hF;
        st_wdata = data_store_data;
        case (data_size)
            2'b00: begin
                legal    = 1'b1;
                st_be    = 4'(4'b0001 << data_address[1:0]);
                st_wdata = {4{data_store_data[7:0]}};
            end
            2'b01: begin
                legal    = ~data_address[0];
                st_be    = data_address[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{data_store_data[15:0]}};
            end
            2'b10:   legal = (data_address[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    // Load extraction uses the access shape latched at grant time.
    always_comb begin
        ld_byte = 8'(ext_read_data >> {lane_q, 3'b000});
        ld_half = lane_q[1] ? ext_read_data[31:16] : ext_read_data[15:0];
        case (size_q)
            2'b00:   ld_ext = {{24{signed_q & ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = {{16{signed_q & ld_half[15]}}, ld_half};
            default: ld_ext = ext_read_data;
        endcase
    end

`ifdef BUS_ARB_FAIR_EN
    logic fair_q, fair_d;

    assign pick_fetch = fetch_req & (fair_q | ~(data_req & legal));

    always_comb begin
        fair_d = fair_q;
        if (state_q == IDLE) begin
            if (pick_fetch)
                fair_d = 1'b0;
            else if (data_req && legal && fetch_req)
                fair_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) fair_q <= 1'b0;
        else       fair_q <= fair_d;
    end
`else
    assign pick_fetch = fetch_req & ~(data_req & legal);
`endif

    always_comb begin
        state_d       = state_q;
        ext_valid_d   = ext_valid_q;
        ext_write_d   = ext_write_q;
        ext_address_d = ext_address_q;
        ext_be_d      = ext_be_q;
        ext_wdata_d   = ext_wdata_q;
        fetch_data_d  = fetch_data_q;
        load_data_d   = load_data_q;
        fetch_ready_d = 1'b0;
        data_ready_d  = 1'b0;
        lane_d        = lane_q;
        size_d        = size_q;
        signed_d      = signed_q;
        unique case (state_q)
            IDLE: begin
                if (pick_fetch) begin
                    state_d       = FETCH;
                    ext_valid_d   = 1'b1;
                    ext_write_d   = 1'b0;
                    ext_address_d = {fetch_address[31:2], 2'b00};
                    ext_be_d      = 4'hF;
                    ext_wdata_d   = '0;
                end else if (data_req && legal) begin
                    state_d       = DATA;
                    ext_valid_d   = 1'b1;
                    ext_write_d   = data_store;
                    ext_address_d = {data_address[31:2], 2'b00};
                    ext_be_d      = data_store ? st_be : 4'hF;
                    ext_wdata_d   = data_store ? st_wdata : '0;
                    lane_d        = data_address[1:0];
                    size_d        = data_size;
                    signed_d      = data_signed;
                end else if (data_req) begin
                    state_d      = RESP;
                    data_ready_d = 1'b1;
                    load_data_d  = '0;
                end
            end
            FETCH: begin
                if (ext_ready) begin
                    state_d       = RESP;
                    ext_valid_d   = 1'b0;
                    ext_write_d   = 1'b0;
                    fetch_ready_d = 1'b1;
                    fetch_data_d  = ext_read_data;
                end
            end
            DATA: begin
                if (ext_ready) begin
                    state_d      = RESP;
                    ext_valid_d  = 1'b0;
                    ext_write_d  = 1'b0;
                    data_ready_d = 1'b1;
                    load_data_d  = ext_write_q ? '0 : ld_ext;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            ext_valid_q   <= 1'b0;
            ext_write_q   <= 1'b0;
            ext_address_q <= '0;
            ext_be_q      <= '0;
            ext_wdata_q   <= '0;
            fetch_data_q  <= '0;
            load_data_q   <= '0;
            fetch_ready_q <= 1'b0;
            data_ready_q  <= 1'b0;
            lane_q        <= '0;
            size_q        <= '0;
            signed_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            ext_valid_q   <= ext_valid_d;
            ext_write_q   <= ext_write_d;
            ext_address_q <= ext_address_d;
            ext_be_q      <= ext_be_d;
            ext_wdata_q   <= ext_wdata_d;
            fetch_data_q  <= fetch_data_d;
            load_data_q   <= load_data_d;
            fetch_ready_q <= fetch_ready_d;
            data_ready_q  <= data_ready_d;
            lane_q        <= lane_d;
            size_q        <= size_d;
            signed_q      <= signed_d;
        end
    end

    assign fetch_data      = fetch_data_q;
    assign fetch_ready     = fetch_ready_q;
    assign data_load_data  = load_data_q;
    assign data_ready      = data_ready_q;
    assign ext_valid       = ext_valid_q;
    assign ext_write       = ext_write_q;
    assign ext_address     = ext_address_q;
    assign ext_byte_enable = ext_be_q;
    assign ext_write_data  = ext_wdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed requests, queued bus and response expectations.
// Build with +define+BUS_ARB_FAIR_EN to check the fair arbitration order.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_address = '0;
    logic [31:0] fetch_data;
    logic        fetch_ready;
    logic        data_load = 1'b0;
    logic        data_store = 1'b0;
    logic [31:0] data_address = '0;
    logic [31:0] data_store_data = '0;
    logic [1:0]  data_size = '0;
    logic        data_signed = 1'b0;
    logic [31:0] data_load_data;
    logic        data_ready;
    logic        ext_valid;
    logic        ext_write;
    logic [31:0] ext_address;
    logic [3:0]  ext_byte_enable;
    logic [31:0] ext_write_data;
    logic        ext_ready = 1'b0;
    logic [31:0] rd_word = '0;

    bus_arbiter dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_address(fetch_address),
        .fetch_data(fetch_data), .fetch_ready(fetch_ready),
        .data_load(data_load), .data_store(data_store),
        .data_address(data_address), .data_store_data(data_store_data),
        .data_size(data_size), .data_signed(data_signed),
        .data_load_data(data_load_data), .data_ready(data_ready),
        .ext_valid(ext_valid), .ext_write(ext_write),
        .ext_address(ext_address), .ext_byte_enable(ext_byte_enable),
        .ext_write_data(ext_write_data), .ext_ready(ext_ready),
        .ext_read_data(rd_word)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    int t0 = 0;
    int waits = 0;
    int wcnt = 0;
    bit valid_seen = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          cyc;
    } bus_t;

    typedef struct {
        logic        is_fetch;
        logic        chk_data;
        logic [31:0] data;
        int          cyc;
    } rsp_t;

    bus_t bus_q[$];
    rsp_t rsp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_bus(input logic wr, input logic [31:0] a, input logic [3:0] be,
                            input logic [31:0] wd, input int c);
        bus_t e;
        e.wr = wr; e.addr = a; e.be = be; e.wdata = wd; e.cyc = c;
        bus_q.push_back(e);
    endtask

    task automatic push_rsp(input logic f, input logic cd, input logic [31:0] d, input int c);
        rsp_t e;
        e.is_fetch = f; e.chk_data = cd; e.data = d; e.cyc = c;
        rsp_q.push_back(e);
    endtask

    // Slave: ext_ready after `waits` idle cycles of ext_valid.
    always @(negedge clk) begin
        if (ext_valid) begin
            ext_ready = (wcnt == waits);
            wcnt++;
        end else begin
            ext_ready = 1'b0;
            wcnt = 0;
        end
    end

    // Monitor: pops expectations when the DUT completes something.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (ext_valid) valid_seen = 1;
            if (!reset && ext_valid && ext_ready) begin
                if (bus_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL bus_unexpected: got access at %h, expected none", ext_address);
                end else begin
                    bus_t e;
                    e = bus_q.pop_front();
                    chk("ext_write", ext_write, e.wr);
                    chk("ext_address", ext_address, e.addr);
                    chk("ext_byte_enable", ext_byte_enable, e.be);
                    if (e.wr) chk("ext_write_data", ext_write_data, e.wdata);
                    chk("bus_cycle", cyc - t0, e.cyc);
                end
            end
            if (!reset && (fetch_ready || data_ready)) begin
                if (rsp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL rsp_unexpected: got f=%b d=%b, expected none", fetch_ready, data_ready);
                end else begin
                    rsp_t e;
                    e = rsp_q.pop_front();
                    chk("rsp_fetch_ready", fetch_ready, e.is_fetch);
                    chk("rsp_data_ready", data_ready, !e.is_fetch);
                    if (e.is_fetch) chk("fetch_data", fetch_data, e.data);
                    else if (e.chk_data) chk("data_load_data", data_load_data, e.data);
                    chk("rsp_cycle", cyc - t0, e.cyc);
                end
            end
        end
    end

    task automatic start();
        @(negedge clk);
        t0 = cyc;
    endtask

    task automatic wait_ready(input logic f);
        bit got;
        got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            #2;
            got = f ? fetch_ready : data_ready;
        end
        if (!got) begin
            n_vec++; n_err++;
            $display("FAIL timeout: got no %s ready, expected a pulse", f ? "fetch" : "data");
        end
    endtask

    task automatic do_fetch(input logic [31:0] a);
        fetch_address = a;
        fetch_req = 1'b1;
        wait_ready(1'b1);
        fetch_req = 1'b0;
    endtask

    task automatic do_data(input logic st, input logic ld, input logic [31:0] a,
                           input logic [31:0] sd, input logic [1:0] sz, input logic sg);
        data_store = st;
        data_load = ld;
        data_address = a;
        data_store_data = sd;
        data_size = sz;
        data_signed = sg;
        wait_ready(1'b0);
        data_store = 1'b0;
        data_load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ext_valid", ext_valid, 0);
        chk("rst_ext_write", ext_write, 0);
        chk("rst_ext_address", ext_address, 0);
        chk("rst_ext_be", ext_byte_enable, 0);
        chk("rst_ext_wdata", ext_write_data, 0);
        chk("rst_fetch_ready", fetch_ready, 0);
        chk("rst_data_ready", data_ready, 0);
        chk("rst_fetch_data", fetch_data, 0);
        chk("rst_load_data", data_load_data, 0);
        reset = 1'b0;

        waits = 0;
        rd_word = 32'hDEADBEEF;
        start();
        push_bus(0, 32'h100, 4'hF, 0, 1);
        push_rsp(1, 1, 32'hDEADBEEF, 2);
        do_fetch(32'h100);

        rd_word = 32'h80FF0000;
        start();
        push_bus(0, 32'h200, 4'hF, 0, 1);
        push_rsp(0, 1, 32'hFFFFFF80, 2);
        do_data(0, 1, 32'h203, 0, 2'b00, 1);
        start();
        push_bus(0, 32'h200, 4'hF, 0, 1);
        push_rsp(0, 1, 32'h00000080, 2);
        do_data(0, 1, 32'h203, 0, 2'b00, 0);

        start();
        push_bus(1, 32'h300, 4'b1100, 32'hABCDABCD, 1);
        push_rsp(0, 0, 0, 2);
        do_data(1, 0, 32'h302, 32'h0000ABCD, 2'b01, 0);

        start();
        push_bus(1, 32'h500, 4'b0010, 32'h77777777, 1);
        push_rsp(0, 0, 0, 2);
        do_data(1, 0, 32'h501, 32'h12345677, 2'b00, 0);

        rd_word = 32'h80017FFF;
        start();
        push_bus(0, 32'h600, 4'hF, 0, 1);
        push_rsp(0, 1, 32'hFFFF8001, 2);
        do_data(0, 1, 32'h602, 0, 2'b01, 1);
        start();
        push_bus(0, 32'h600, 4'hF, 0, 1);
        push_rsp(0, 1, 32'h00007FFF, 2);
        do_data(0, 1, 32'h600, 0, 2'b01, 1);

        start();
        push_bus(1, 32'h704, 4'hF, 32'hCAFEF00D, 1);
        push_rsp(0, 0, 0, 2);
        do_data(1, 1, 32'h704, 32'hCAFEF00D, 2'b10, 0);

        rd_word = 32'h89ABCDEF;
        start();
        push_bus(0, 32'h708, 4'hF, 0, 1);
        push_rsp(0, 1, 32'h89ABCDEF, 2);
        do_data(0, 1, 32'h708, 0, 2'b10, 1);

        waits = 2;
        rd_word = 32'h11223344;
        start();
        push_bus(0, 32'h900, 4'hF, 0, 3);
        push_rsp(0, 1, 32'h11223344, 4);
        push_bus(0, 32'h800, 4'hF, 0, 8);
        push_rsp(1, 1, 32'h11223344, 9);
        fork
            do_fetch(32'h800);
            do_data(0, 1, 32'h900, 0, 2'b10, 0);
        join

        waits = 0;
        rd_word = 32'h55AA55AA;
        start();
        push_bus(0, 32'hA00, 4'hF, 0, 1);
        push_rsp(0, 1, 32'h55AA55AA, 2);
`ifdef BUS_ARB_FAIR_EN
        push_bus(0, 32'hB00, 4'hF, 0, 4);
        push_rsp(1, 1, 32'h55AA55AA, 5);
        push_bus(0, 32'hA04, 4'hF, 0, 7);
        push_rsp(0, 1, 32'h55AA55AA, 8);
`else
        push_bus(0, 32'hA04, 4'hF, 0, 4);
        push_rsp(0, 1, 32'h55AA55AA, 5);
        push_bus(0, 32'hB00, 4'hF, 0, 7);
        push_rsp(1, 1, 32'h55AA55AA, 8);
`endif
        fork
            do_fetch(32'hB00);
            begin
                data_address = 32'hA00;
                data_size = 2'b10;
                data_signed = 1'b0;
                data_load = 1'b1;
                wait_ready(1'b0);
                data_address = 32'hA04;
                wait_ready(1'b0);
                data_load = 1'b0;
            end
        join

        start();
        valid_seen = 0;
        push_rsp(0, 1, 32'h0, 1);
        do_data(0, 1, 32'hC00, 0, 2'b11, 0);
        start();
        push_rsp(0, 1, 32'h0, 1);
        do_data(1, 0, 32'h401, 32'h1234, 2'b01, 0);
        @(negedge clk);
        chk("illegal_no_ext_valid", valid_seen, 0);

        waits = 10;
        start();
        data_address = 32'hD00;
        data_size = 2'b10;
        data_load = 1'b1;
        for (int i = 0; i < 5 && !ext_valid; i++) begin
            @(negedge clk);
            #2;
        end
        chk("abort_valid_before", ext_valid, 1);
        #1 reset = 1'b1;
        #1;
        chk("abort_ext_valid", ext_valid, 0);
        chk("abort_fetch_ready", fetch_ready, 0);
        chk("abort_data_ready", data_ready, 0);
        data_load = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        waits = 0;
        rd_word = 32'h0BADF00D;
        start();
        push_bus(0, 32'hE0C, 4'hF, 0, 1);
        push_rsp(1, 1, 32'h0BADF00D, 2);
        do_fetch(32'hE0E);

        repeat (3) @(negedge clk);
        chk("bus_queue_drained", bus_q.size(), 0);
        chk("rsp_queue_drained", rsp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
